// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter, the receiver and the display glue.
// Contents: frame state enum, data/stop-bit widths and a bit-period divider helper.
package uart_pkg;

  localparam int unsigned UART_DATA_W    = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  // StParity is only reachable when the transmitter is built with parity enabled.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Bit period in system clocks (integer floor); callers must keep the result >= 2.
  function automatic int unsigned uart_calc_div(input int unsigned clk_freq,
                                                input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level handshake between a UART transmitter and its client.
//   send_data  : byte to transmit, sampled when the request is accepted
//   send_start : request strobe, level-sampled every cycle while idle
//   txd        : serial line, idle high
//   busy       : frame in progress
//   done       : one-cycle pulse on the last cycle of a frame
// master = client driving requests, slave = transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] send_data;
  logic                   send_start;
  logic                   txd;
  logic                   busy;
  logic                   done;

  modport master (
    output send_data,
    output send_start,
    input  txd,
    input  busy,
    input  done
  );

  modport slave (
    input  send_data,
    input  send_start,
    output txd,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: a counter running 0..Div-1 that pulses tick_o on the last count.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   clear_i    : synchronous restart from 0 (used when a new frame is accepted)
//   tick_o     : one-cycle pulse every Div cycles (counter at Div-1)
//   pre_tick_o : high one cycle before tick_o (counter at Div-2)
module uart_baud_gen #(
  parameter int unsigned Div = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o,
  output logic pre_tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
  localparam logic [CntW-1:0] CntPre  = CntW'(Div - 2);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o     = (cnt_q == CntLast);
  assign pre_tick_o = (cnt_q == CntPre);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: shifts a byte out on txd as 8N1, LSB first, paced by an internal baud
// tick of DIV = CLK_FREQ / BAUD clocks. Define UART_TX_PARITY_EN to insert an even-parity
// bit between data bit 7 and the stop bit (8E1).
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : uart_tx_if slave (send_data, send_start in; txd, busy, done out)
// All outputs come straight from flops, so txd is glitch-free and idles high in reset.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus
);

  localparam int unsigned DIV = uart_calc_div(CLK_FREQ, BAUD);

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   txd_q, txd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic baud_clear;
  logic tick;
  logic pre_tick;

  uart_baud_gen #(
    .Div(DIV)
  ) u_baud_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (baud_clear),
    .tick_o     (tick),
    .pre_tick_o (pre_tick)
  );

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.send_start) begin
          state_d    = StStart;
          shift_d    = bus.send_data;
          bit_idx_d  = '0;
          baud_clear = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^bus.send_data;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
    // Counter sits at DIV-2 one cycle before the last stop cycle.
    done_d = (state_q == StStop) && pre_tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign bus.txd  = txd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
